// File: rtl/mag_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: result codes and FSM state encoding.
package mag_cmp_pkg;

  localparam logic [1:0] CMP_ZERO = 2'b00;
  localparam logic [1:0] CMP_GT   = 2'b01;
  localparam logic [1:0] CMP_LT   = 2'b10;
  localparam logic [1:0] CMP_EQ   = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/mag_cmp_bit.sv
// Single bit-pair decision; invert flips the sense for the sign bit of two's-complement operands.
module mag_cmp_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic invert_i,
  output logic gt_o,
  output logic lt_o
);

  logic a_wins;
  logic b_wins;

  always_comb begin
    a_wins = a_i & ~b_i;
    b_wins = ~a_i & b_i;
    gt_o   = invert_i ? b_wins : a_wins;
    lt_o   = invert_i ? a_wins : b_wins;
  end

endmodule

// File: rtl/mag_compare_serial.sv
// Bit-serial magnitude comparator: scans captured operands MSB first and stops at the first
// differing bit pair.
module mag_compare_serial
  import mag_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             signed_mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       r_o
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic             zero_q, zero_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [1:0]       r_q, r_d;

  logic bit_gt;
  logic bit_lt;

  mag_cmp_bit u_bit (
    .a_i      (a_q[idx_q]),
    .b_i      (b_q[idx_q]),
    .invert_i (signed_q && (idx_q == IdxMsb)),
    .gt_o     (bit_gt),
    .lt_o     (bit_lt)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    zero_d   = zero_q;
    idx_d    = idx_q;
    r_d      = r_q;

    unique case (state_q)
      StIdle: begin
        // start wins over clear here; clear only acts on a comparison in progress
        if (start_i) begin
          a_d      = a_i;
          b_d      = b_i;
          signed_d = signed_mode_i;
          zero_d   = (a_i == '0) && (b_i == '0);
          idx_d    = IdxMsb;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (clear_i) begin
          state_d = StIdle;
        end else if (bit_gt) begin
          r_d     = CMP_GT;
          state_d = StDone;
        end else if (bit_lt) begin
          r_d     = CMP_LT;
          state_d = StDone;
        end else if (idx_q == '0) begin
          r_d     = zero_q ? CMP_ZERO : CMP_EQ;
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      zero_q   <= 1'b0;
      idx_q    <= IdxMsb;
      r_q      <= CMP_ZERO;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      zero_q   <= zero_d;
      idx_q    <= idx_d;
      r_q      <= r_d;
    end
  end

  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
    r_o    = r_q;
  end

endmodule

// File: tb/tb_mag_compare_serial.sv
// Directed self-checking bench for mag_compare_serial at WIDTH=8.
module tb_mag_compare_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic       signed_mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [1:0] r;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  mag_compare_serial #(
    .WIDTH (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .clear_i       (clear),
    .signed_mode_i (signed_mode),
    .a_i           (a),
    .b_i           (b),
    .busy_o        (busy),
    .done_o        (done),
    .r_o           (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a comparison, scramble the inputs right after capture, and wait (bounded) for done.
  // exp_e is the edge index (start edge = 1) after which done is high.
  task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                         input logic clr, input int exp_e, input logic [1:0] exp_r,
                         input string tag);
    int e;
    int nbusy;
    int d0;
    bit got;
    @(negedge clk);
    a = av; b = bv; signed_mode = sm; start = 1'b1; clear = clr;
    d0 = done_cnt; e = 1; nbusy = 0; got = 0;
    @(posedge clk);
    #1;
    start = 1'b0; clear = 1'b0;
    a = ~av; b = ~bv; signed_mode = ~sm;
    if (busy) nbusy++;
    while (!got && e < 40) begin
      @(posedge clk);
      e++;
      #1;
      if (busy) nbusy++;
      if (done) got = 1;
    end
    check({tag, "_edges"}, e, exp_e);
    check({tag, "_r"}, {30'd0, r}, {30'd0, exp_r});
    check({tag, "_busy_cycles"}, nbusy, exp_e - 1);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_r", {30'd0, r}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmp(8'h80, 8'h7F, 1'b0, 1'b0, 2, 2'b01, "u_80_7f");
    run_cmp(8'h80, 8'h7F, 1'b1, 1'b0, 2, 2'b10, "s_80_7f");
    run_cmp(8'hFF, 8'hFE, 1'b1, 1'b0, 9, 2'b01, "s_ff_fe");
    run_cmp(8'h00, 8'h00, 1'b0, 1'b0, 9, 2'b00, "zero");
    run_cmp(8'h5A, 8'h5A, 1'b0, 1'b0, 9, 2'b11, "eq_5a");
    run_cmp(8'h0F, 8'h2F, 1'b0, 1'b0, 4, 2'b10, "u_0f_2f");
    run_cmp(8'h05, 8'hFB, 1'b1, 1'b0, 2, 2'b01, "s_05_fb");
    run_cmp(8'h80, 8'h80, 1'b1, 1'b0, 9, 2'b11, "s_eq_80");
    // start and clear together in IDLE: start must win
    run_cmp(8'h12, 8'h13, 1'b0, 1'b1, 9, 2'b10, "start_clear");

    // Second start during RUN is ignored; only one done, result from first operands.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h10; b = 8'h20; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("ignore_start_done_count", done_cnt - d0, 1);
    check("ignore_start_r", {30'd0, r}, 32'd2);
    check("ignore_start_idle", {31'd0, busy}, 32'd0);

    // Clear on the 4th RUN edge (edge 5): abort with no done and r unchanged.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h33; b = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_busy", {31'd0, busy}, 32'd0);
    check("clear_done", {31'd0, done}, 32'd0);
    check("clear_r_kept", {30'd0, r}, 32'd2);
    repeat (10) @(negedge clk);
    check("clear_no_done", done_cnt - d0, 0);
    run_cmp(8'h33, 8'h33, 1'b0, 1'b0, 9, 2'b11, "after_clear");

    // Asynchronous reset mid-RUN.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h5A; b = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_r", {30'd0, r}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_no_done", done_cnt - d0, 0);
    run_cmp(8'h01, 8'h00, 1'b0, 1'b0, 9, 2'b01, "post_reset");

    // Start present on the very first edge after reset release must be accepted.
    @(negedge clk);
    rst_n = 1'b0;
    a = 8'hC0; b = 8'h40; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_edge_start", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("first_edge_done", {31'd0, done}, 32'd1);
    check("first_edge_r", {30'd0, r}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mag_compare_serial.md
MAG_COMPARE_SERIAL -- requirements
Module: mag_compare_serial

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a comparison; sampled only in IDLE.
REQ-005 clear  input  1  synchronous abort of a comparison in progress.
REQ-006 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
REQ-007 a  input  WIDTH  operand A; captured on an accepted start.
REQ-008 b  input  WIDTH  operand B; captured on an accepted start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse when r holds a new result.
REQ-011 r  output  2  result code: 00 = A=B=0; 01 = A>B; 10 = A<B; 11 = A=B, nonzero.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at an edge SHALL capture a, b and signed_mode into internal registers, set bit index to WIDTH-1, precompute zero = (a==0 && b==0), and enter RUN.
REQ-014 Each RUN edge SHALL compare captured bit pair a[idx], b[idx], MSB first.
REQ-015 Unsigned, or idx < WIDTH-1: a=1,b=0 means A>B; a=0,b=1 means A<B.
REQ-016 Signed mode at idx=WIDTH-1 SHALL invert the sense: a=1,b=0 means A<B; a=0,b=1 means A>B.
REQ-017 First differing pair SHALL load r with 01 or 10 and enter DONE (early termination).
REQ-018 Equal pair with idx=0 SHALL load r with 00 if zero else 11 and enter DONE.
REQ-019 Equal pair with idx>0 SHALL decrement idx and stay in RUN.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-021 Latency: if k bit pairs are examined (1..WIDTH), done SHALL be high in the cycle following the (k+1)-th rising edge after the start edge, counting the start edge as edge 1.
REQ-022 r SHALL hold its value from one result until the next result is loaded; it SHALL not change in IDLE or RUN.
REQ-023 start in RUN or DONE SHALL be ignored; no queuing.
REQ-024 Changes on a, b or signed_mode after capture SHALL not affect the result in progress.
REQ-025 clear=1 in RUN SHALL return to IDLE at that edge with no done pulse and r unchanged.
REQ-026 clear takes priority over a decision in the same edge.
REQ-027 clear in IDLE or DONE SHALL have no effect.
REQ-028 start and clear both high in IDLE: start SHALL win.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, busy=0, done=0, r=00, idx=WIDTH-1, captured operands 0.
REQ-030 Reset asserted mid-RUN SHALL discard the comparison with no done pulse.
REQ-031 After release, the first start SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-032 Shared package mag_cmp_pkg SHALL hold the result-code constants (CMP_ZERO=00, CMP_GT=01, CMP_LT=10, CMP_EQ=11) and the FSM state encoding.
REQ-033 One sub-module, mag_cmp_bit, SHALL perform the single bit-pair decision: inputs a bit, b bit, invert; outputs gt, lt.
REQ-034 Index width SHALL be derived as clog2(WIDTH).

Verification (WIDTH=8)
REQ-035 Unsigned a=0x80, b=0x7F -> r=01, done 2 edges after the start edge (MSB decides).
REQ-036 Signed a=0x80 (-128), b=0x7F -> r=10; signed a=0xFF, b=0xFE -> r=01 after 8 bits, done 9 edges after start.
REQ-037 a=b=0x00 -> r=00; a=b=0x5A -> r=11; both take 9 edges, busy high for 8 cycles.
REQ-038 a=0x10, b=0x20 started, then start pulsed in RUN with a=0xFF -> single done, r=10; second start ignored.
REQ-039 Start a=b=0x33, assert clear on the 4th RUN edge -> IDLE, no done, r keeps its previous value; new start then completes normally.
REQ-040 Assert rst_n low mid-RUN, asynchronously to clk -> busy, done and r drop to 0 immediately; no done pulse after release.
